// File: rtl/bus_mux_pkg.sv
// rtl/bus_mux_pkg.sv - shared bus helpers: clog2, grant-index width, default bus sizes
`ifndef BUS_MUX_PKG_SV
`define BUS_MUX_PKG_SV

package bus_mux_pkg;

    localparam int BUS_MUX_DEFAULT_WIDTH    = 4;
    localparam int BUS_MUX_DEFAULT_CHANNELS = 2;
    localparam int BUS_MUX_MAX_CHANNELS     = 16;

    // Ceiling log2; bounded loop so it stays a legal constant function.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Width of a channel index; a single bit is kept even for one channel.
    function automatic int sel_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

`define BUS_MUX_SEL_W(ch) bus_mux_pkg::sel_width(ch)

`endif

// File: rtl/bus_mux_arbiter_if.sv
// rtl/bus_mux_arbiter_if.sv - handshake bundle between channel sources, mux and internal bus
interface bus_mux_arbiter_if
    import bus_mux_pkg::*;
#(
    parameter int WIDTH    = BUS_MUX_DEFAULT_WIDTH,
    parameter int CHANNELS = BUS_MUX_DEFAULT_CHANNELS
);
    localparam int SEL_W = `BUS_MUX_SEL_W(CHANNELS);

    logic                       enable_n;
    logic [CHANNELS-1:0]        in_valid;
    logic [CHANNELS*WIDTH-1:0]  in_data;
    logic [CHANNELS-1:0]        in_ready;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_data;
    logic                       out_ready;
    logic [SEL_W-1:0]           grant_idx;

    modport master (
        output enable_n, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, grant_idx
    );

    modport slave (
        input  enable_n, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, grant_idx
    );

endinterface

// File: rtl/bus_mux_arbiter_rr_arbiter.sv
// rtl/bus_mux_arbiter_rr_arbiter.sv - rotating-priority encoder, lock inputs with BUS_MUX_LOCK_EN
module rr_arbiter
    import bus_mux_pkg::*;
#(
    parameter  int CHANNELS = BUS_MUX_DEFAULT_CHANNELS,
    localparam int SEL_W    = `BUS_MUX_SEL_W(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
`ifdef BUS_MUX_LOCK_EN
    input  logic                lock,
    input  logic [SEL_W-1:0]    lock_idx,
`endif
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                any
);

    logic             lock_on;
    logic [SEL_W-1:0] lock_sel;

`ifdef BUS_MUX_LOCK_EN
    assign lock_on  = lock;
    assign lock_sel = lock_idx;
`else
    assign lock_on  = 1'b0;
    assign lock_sel = '0;
`endif

    int idx;

    // Search ptr, ptr+1, ... wrapping at CHANNELS; lock pins the search to one channel.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        if (lock_on) begin
            gnt_idx = lock_sel;
            any     = (int'(lock_sel) < CHANNELS) && req[lock_sel];
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(ptr) + k;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (!any && req[idx]) begin
                    any     = 1'b1;
                    gnt_idx = idx[SEL_W-1:0];
                end
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bus_mux_arbiter.sv
// rtl/bus_mux_arbiter.sv - round-robin registered bus mux with active-low enable; lock via BUS_MUX_LOCK_EN
module bus_mux_arbiter
    import bus_mux_pkg::*;
#(
    parameter  int WIDTH    = BUS_MUX_DEFAULT_WIDTH,
    parameter  int CHANNELS = BUS_MUX_DEFAULT_CHANNELS,
    localparam int SEL_W    = `BUS_MUX_SEL_W(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef BUS_MUX_LOCK_EN
    input  logic              lock,
`endif
    bus_mux_arbiter_if.slave  bus
);

    logic                held_valid;
    logic [WIDTH-1:0]    data_q;
    logic [SEL_W-1:0]    gidx_q;
    logic [SEL_W-1:0]    ptr_q;

    logic [CHANNELS-1:0] gnt;
    logic [SEL_W-1:0]    gnt_idx;
    logic                any;
    logic                space;
    logic                gate;
    logic                accept;
    logic                lock_on;
    logic [WIDTH-1:0]    sel_data;
    logic [SEL_W-1:0]    ptr_next;

`ifdef BUS_MUX_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr (
        .req      (bus.in_valid),
        .ptr      (ptr_q),
`ifdef BUS_MUX_LOCK_EN
        .lock     (lock),
        .lock_idx (gidx_q),
`endif
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .any      (any)
    );

    // Acceptance gate: room in the output register, enabled, not in reset.
    always_comb begin
        space    = !held_valid || bus.out_ready;
        gate     = space && !bus.enable_n && !rst;
        accept   = any && gate;
        sel_data = bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        ptr_next = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign bus.in_ready  = gate ? gnt : '0;
    assign bus.out_valid = held_valid && !bus.enable_n;
    assign bus.out_data  = (held_valid && !bus.enable_n) ? data_q : '0;
    assign bus.grant_idx = gidx_q;

    // Output register and round-robin pointer; everything frozen while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid <= 1'b0;
            data_q     <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
        end else if (!bus.enable_n) begin
            if (accept) begin
                held_valid <= 1'b1;
                data_q     <= sel_data;
                gidx_q     <= gnt_idx;
                if (!lock_on) begin
                    ptr_q <= ptr_next;
                end
            end else if (bus.out_ready) begin
                held_valid <= 1'b0;
            end
        end
    end

    // At most one channel is ever accepted, and the pointer never leaves the channel range.
    a_ready_onehot : assert property (@(posedge clk) $onehot0(bus.in_ready));
    a_ptr_range    : assert property (@(posedge clk) disable iff (rst) int'(ptr_q) < CHANNELS);

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// tb/tb_bus_mux_arbiter.sv - checks 2- and 3-channel muxes against a behavioural model
module tb_bus_mux_arbiter;

    logic       clk;
    logic       rst;
    logic       en_n;
    logic       ordy;
    logic       lock;
    logic [2:0] v;
    logic [3:0] d0, d1, d2;

    int n_cmp = 0;
    int n_bad = 0;

    bus_mux_arbiter_if #(.WIDTH(4), .CHANNELS(2)) b2 ();
    bus_mux_arbiter_if #(.WIDTH(4), .CHANNELS(3)) b3 ();

    assign b2.enable_n  = en_n;
    assign b2.in_valid  = v[1:0];
    assign b2.in_data   = {d1, d0};
    assign b2.out_ready = ordy;
    assign b3.enable_n  = en_n;
    assign b3.in_valid  = v;
    assign b3.in_data   = {d2, d1, d0};
    assign b3.out_ready = ordy;

    bus_mux_arbiter #(.WIDTH(4), .CHANNELS(2)) u2 (
        .clk  (clk),
        .rst  (rst),
`ifdef BUS_MUX_LOCK_EN
        .lock (lock),
`endif
        .bus  (b2)
    );

    bus_mux_arbiter #(.WIDTH(4), .CHANNELS(3)) u3 (
        .clk  (clk),
        .rst  (rst),
`ifdef BUS_MUX_LOCK_EN
        .lock (lock),
`endif
        .bus  (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model state per mux: index 0 is the 2-channel one, index 1 the 3-channel one.
    int m_held[2];
    int m_reg[2];
    int m_gidx[2];
    int m_ptr[2];
    bit m_init[2];

    function automatic int word_of(input int c);
        return (c == 0) ? int'(d0) : (c == 1) ? int'(d1) : int'(d2);
    endfunction

    task automatic model_step(input int d, input int n, input int rdy, input int ov,
                              input int od, input int gi);
        int valid;
        int cand;
        int c;
        bit space;
        int exp_rdy;
        valid = int'(v) & ((1 << n) - 1);
        cand  = -1;
        if (lock) begin
            if (((valid >> m_gidx[d]) & 1) == 1) cand = m_gidx[d];
        end else begin
            for (int k = 0; k < n; k++) begin
                c = (m_ptr[d] + k) % n;
                if (cand < 0 && ((valid >> c) & 1) == 1) cand = c;
            end
        end
        space   = (m_held[d] == 0) || ordy;
        exp_rdy = (!rst && !en_n && space && cand >= 0) ? (1 << cand) : 0;
        chk($sformatf("ch%0d in_ready", n), rdy, exp_rdy);
        if (m_init[d]) begin
            chk($sformatf("ch%0d out_valid", n), ov, (m_held[d] != 0 && !en_n) ? 1 : 0);
            chk($sformatf("ch%0d out_data", n), od, (m_held[d] != 0 && !en_n) ? m_reg[d] : 0);
            chk($sformatf("ch%0d grant_idx", n), gi, m_gidx[d]);
        end
        if (rst) begin
            m_held[d] = 0; m_reg[d] = 0; m_gidx[d] = 0; m_ptr[d] = 0; m_init[d] = 1'b1;
        end else if (!en_n) begin
            if (exp_rdy != 0) begin
                m_held[d] = 1;
                m_reg[d]  = word_of(cand);
                m_gidx[d] = cand;
                if (!lock) m_ptr[d] = (cand + 1) % n;
            end else if (ordy) begin
                m_held[d] = 0;
            end
        end
    endtask

    // Every negative edge: compare both muxes against the model, then advance it.
    always @(negedge clk) begin
        model_step(0, 2, int'(b2.in_ready), int'(b2.out_valid), int'(b2.out_data), int'(b2.grant_idx));
        model_step(1, 3, int'(b3.in_ready), int'(b3.out_valid), int'(b3.out_data), int'(b3.grant_idx));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #2;
    endtask

    int seq [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst = 1'b1; en_n = 1'b0; ordy = 1'b1; lock = 1'b0;
        v = 3'b111; d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;

        // Reset with all inputs valid, then disabled with all inputs valid.
        repeat (2) begin
            tick(); mid();
            chk("rst out_valid", int'(b2.out_valid), 0);
            chk("rst out_data", int'(b2.out_data), 0);
            chk("rst in_ready", int'(b2.in_ready), 0);
            chk("rst grant_idx", int'(b2.grant_idx), 0);
        end
        tick();
        rst = 1'b0; en_n = 1'b1;
        repeat (5) begin
            mid();
            chk("dis in_ready2", int'(b2.in_ready), 0);
            chk("dis in_ready3", int'(b3.in_ready), 0);
            chk("dis out_data", int'(b2.out_data), 0);
            tick();
        end

        // Two-channel selector equivalence.
        en_n = 1'b0; d0 = 4'b1010; d1 = 4'b0101; v = 3'b001; ordy = 1'b1;
        mid();
        chk("sel0 in_ready", int'(b2.in_ready), 1);
        tick();
        v = 3'b010;
        mid();
        chk("sel0 out_data", int'(b2.out_data), 4'b1010);
        chk("sel0 grant_idx", int'(b2.grant_idx), 0);
        chk("sel1 in_ready", int'(b2.in_ready), 2);
        tick();
        v = 3'b000;
        mid();
        chk("sel1 out_data", int'(b2.out_data), 4'b0101);
        chk("sel1 grant_idx", int'(b2.grant_idx), 1);
        tick();
        mid();
        chk("drain out_valid", int'(b2.out_valid), 0);
        chk("drain grant_idx", int'(b2.grant_idx), 1);
        tick();

        // Round-robin over three channels at full rate.
        rst = 1'b1;
        tick();
        rst = 1'b0; v = 3'b111; d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); mid();
            chk("rr grant_idx", int'(b3.grant_idx), seq[i]);
            chk("rr out_data", int'(b3.out_data), seq[i] + 1);
            chk("rr out_valid", int'(b3.out_valid), 1);
        end
        tick();

        // Backpressure then simultaneous drain and refill.
        rst = 1'b1;
        tick();
        rst = 1'b0; v = 3'b111; d0 = 4'h9; d1 = 4'h6; d2 = 4'h3; ordy = 1'b0;
        mid();
        chk("bp first in_ready", int'(b3.in_ready), 1);
        tick();
        d0 = 4'hF;
        repeat (4) begin
            mid();
            chk("bp out_valid", int'(b3.out_valid), 1);
            chk("bp out_data", int'(b3.out_data), 4'h9);
            chk("bp in_ready", int'(b3.in_ready), 0);
            tick();
        end
        ordy = 1'b1;
        mid();
        chk("bp release in_ready", int'(b3.in_ready), 2);
        tick();
        mid();
        chk("bp refill out_data", int'(b3.out_data), 4'h6);
        chk("bp refill grant_idx", int'(b3.grant_idx), 1);
        tick();

        // Enable toggled while a word is held, then reset during the hold.
        rst = 1'b1;
        tick();
        rst = 1'b0; v = 3'b001; d0 = 4'b1100; ordy = 1'b0;
        tick();
        v = 3'b000; en_n = 1'b1;
        repeat (3) begin
            mid();
            chk("en hold out_data", int'(b3.out_data), 0);
            chk("en hold out_valid", int'(b3.out_valid), 0);
            tick();
        end
        en_n = 1'b0;
        mid();
        chk("en back out_data", int'(b3.out_data), 4'b1100);
        chk("en back out_valid", int'(b3.out_valid), 1);
        tick();
        rst = 1'b1;
        mid();
        chk("rst hold in_ready", int'(b3.in_ready), 0);
        tick();
        mid();
        chk("rst hold out_valid", int'(b3.out_valid), 0);
        tick();
        rst = 1'b0;

`ifdef BUS_MUX_LOCK_EN
        // Lock on channel 1, then release: round robin resumes after it.
        v = 3'b010; ordy = 1'b1; d0 = 4'hA; d1 = 4'hB; d2 = 4'hC;
        tick();
        v = 3'b111; lock = 1'b1;
        repeat (3) begin
            tick(); mid();
            chk("lock grant_idx", int'(b3.grant_idx), 1);
            chk("lock out_data", int'(b3.out_data), 4'hB);
        end
        tick();
        lock = 1'b0;
        tick(); mid();
        chk("unlock grant_idx", int'(b3.grant_idx), 2);
        tick();
        // Lock straight after reset: channel 0 held, pointer must stay at 0.
        rst = 1'b1;
        tick();
        rst = 1'b0; lock = 1'b1;
        repeat (2) begin
            tick(); mid();
            chk("lock0 grant_idx", int'(b3.grant_idx), 0);
        end
        tick();
        lock = 1'b0;
        tick(); mid();
        chk("lock0 ptr frozen", int'(b3.grant_idx), 0);
        tick();
        v = 3'b000;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_mux_arbiter.md
Name: bus_mux_arbiter

Overview:
- Parametrised successor to the quad 2:1 TTL-style data selector.
- Selects one of CHANNELS input words of WIDTH bits onto a single registered output bus.
- Replaces the static select line with round-robin arbitration over per-channel valid/ready handshakes.
- Keeps the active-low enable semantics: output forced to zero when disabled. Sits between register-file/ALU sources and the CPU internal data bus.

Parameters:
- WIDTH, 4, data bits per channel (>=1)
- CHANNELS, 2, number of input channels (2..16)
- SEL_W, derived = max(1, clog2(CHANNELS)), width of grant index; not user-overridden

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- enable_n  in  1  active-low output enable / acceptance gate
- in_valid  in  CHANNELS  per-channel request; bit i belongs to channel i
- in_data  in  CHANNELS*WIDTH  packed input words; channel i at [i*WIDTH +: WIDTH]
- in_ready  out  CHANNELS  per-channel accept; one-hot or zero
- out_valid  out  1  output register holds an untaken word (masked by enable_n)
- out_data  out  WIDTH  output word; 0 whenever enable_n=1 or no valid word
- out_ready  in  1  downstream accepts out_data this cycle
- grant_idx  out  SEL_W  channel index of the word currently in the output register

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, data register=0, grant_idx=0, rr pointer=0. in_ready=0 during reset. Overrides any in-flight transfer; the held word is discarded.
- Arbiter: combinational. Candidate = first i with in_valid[i]=1, searching ptr, ptr+1, ... wrapping modulo CHANNELS.
- space = !held_valid || out_ready.
- in_ready[candidate] = space && !enable_n && !rst; all other bits 0.
- Accept occurs when in_valid[i] && in_ready[i]. Next edge: data register <= channel i word, held_valid <= 1, grant_idx <= i, ptr <= (i+1) mod CHANNELS (wraps from CHANNELS-1 to 0).
- Latency: 1 cycle from accept to out_valid. Throughput: 1 word/cycle when out_ready is held high (simultaneous drain and refill).
- Drain without refill (out_ready=1, no accept): held_valid <= 0. Data register and grant_idx keep their last value.
- Hold: held_valid=1 and out_ready=0 leaves the register, grant_idx and ptr unchanged. in_ready is all zeros.
- out_valid = held_valid && !enable_n.
- out_data = (held_valid && !enable_n) ? register : 0.
- enable_n=1:
  - in_ready all zeros; out_ready ignored.
  - Held word is retained and reappears when enable_n returns low.
  - ptr frozen.
- No valid inputs: in_ready=0; ptr unchanged.
- CHANNELS non-power-of-2: ptr and index arithmetic wrap at CHANNELS, never at 2^SEL_W.
- Input data is sampled only at the accept edge. Changes to in_data while not ready have no effect.

Optional Feature:
- Macro: BUS_MUX_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1, candidate is restricted to the channel in grant_idx. Other channels get in_ready=0 even if they are valid.
  - ptr is not advanced on accepts made under lock.
  - lock=1 with that channel not valid gives no accept that cycle.
- Undefined: no lock port; pure round-robin as above.

Decomposition:
- Shared package/include bus_mux_pkg: clog2 function, SEL_W derivation macro, default WIDTH/CHANNELS constants reused by other bus blocks.
- Sub-module rr_arbiter: combinational rotating-priority encoder.
  - Params: CHANNELS.
  - Inputs: req[CHANNELS], ptr[SEL_W], optional lock/lock_idx.
  - Outputs: gnt onehot, gnt_idx, any.
- Top module holds the output register, ptr register and handshake logic.

Test Plan:
1. Reset and enable masking: rst=1 for 2 cycles with in_valid=2'b11 -> out_valid=0, out_data=0, in_ready=00, grant_idx=0. Then enable_n=1, in_valid=11 for 5 cycles -> in_ready=00, out_data=0.
2. 74157 equivalence: CHANNELS=2, WIDTH=4, ch0=4'b1010, ch1=4'b0101, only ch0 valid, out_ready=1 -> in_ready=01; next cycle out_data=1010, grant_idx=0. Only ch1 valid -> out_data=0101, grant_idx=1.
3. Round-robin fairness: CHANNELS=3, all valid, out_ready=1 for 6 cycles -> grant_idx sequence 0,1,2,0,1,2, one word per cycle.
4. Backpressure: out_ready=0 after first accept -> out_valid stays 1, out_data stable, in_ready=000 for 4 cycles. Raise out_ready -> drain and refill on the same edge.
5. Enable mid-hold: word 4'b1100 held, enable_n=1 for 3 cycles -> out_data=0, out_valid=0. enable_n=0 -> out_data=1100, out_valid=1 again. Sync reset during hold -> out_valid=0 at next edge.
6. BUS_MUX_LOCK_EN: grant ch1, assert lock with all channels valid -> ch1 granted repeatedly, grant_idx=1. Deassert lock -> next grant is ch2 (CHANNELS=3).
